// File: rtl/alu_arbiter.sv
// Two-requester sequencer in front of a shared combinational mini_alu.
// One operation in flight: IDLE (arbitrate) -> EXEC (ALU evaluates) -> RESP (hold response).
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic              req0_use_carry,
    input  logic              req0_set_cc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_opcode,
    input  logic              req1_use_carry,
    input  logic              req1_set_cc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic [3:0]        rsp_flags,
    output logic [3:0]        icc,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              use_carry;
        logic              set_cc;
    } req_t;

    state_t            r_state, w_next;
    req_t              r_opr;
    logic              r_id;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_rsp_y;
    logic [3:0]        r_rsp_flags;
    logic              r_rsp_id;
    logic [3:0]        r_icc;

    req_t              w_req0, w_req1;
    logic              w_gnt0, w_gnt1, w_accept;

    assign w_req0 = '{a: req0_a, b: req0_b, op: req0_opcode,
                      use_carry: req0_use_carry, set_cc: req0_set_cc};
    assign w_req1 = '{a: req1_a, b: req1_b, op: req1_opcode,
                      use_carry: req1_use_carry, set_cc: req1_set_cc};

    // On contention, the requester not granted last time wins.
    assign w_gnt0   = req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1   = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy       = 1'b0;
                req0_ready = w_gnt0;
                req1_ready = w_gnt1;
                if (w_gnt0 || w_gnt1) w_next = S_EXEC;
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opr        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_y      <= '0;
            r_rsp_flags  <= '0;
            r_rsp_id     <= 1'b0;
            r_icc        <= '0;
        end else begin
            if (w_accept) begin
                r_opr        <= w_gnt1 ? w_req1 : w_req0;
                r_id         <= w_gnt1;
                r_last_grant <= w_gnt1;
            end
            if (r_state == S_EXEC) begin
                r_rsp_y     <= alu_y;
                r_rsp_flags <= alu_flags;
                r_rsp_id    <= r_id;
                if (r_opr.set_cc) r_icc <= alu_flags;
            end
        end
    end

    // Carry-in reads icc as it stood before this operation's own update.
    assign alu_a      = r_opr.a;
    assign alu_b      = r_opr.b;
    assign alu_opcode = r_opr.op;
    assign alu_cin    = r_opr.use_carry & r_icc[0];

    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_flags = r_rsp_flags;
    assign icc       = r_icc;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a stand-in mini_alu, a transaction-level
// reference model feeding an expected-response queue, and a separate monitor.
module tb_alu_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid [2];
    logic [DW-1:0] req_a     [2];
    logic [DW-1:0] req_b     [2];
    logic [3:0]    req_op    [2];
    logic          req_uc    [2];
    logic          req_sc    [2];
    logic          req0_ready, req1_ready;
    logic [DW-1:0] alu_a, alu_b, alu_y, rsp_y;
    logic [3:0]    alu_opcode, alu_flags, rsp_flags, icc;
    logic          alu_cin, rsp_valid, rsp_ready, rsp_id, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req0_ready),
        .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_opcode(req_op[0]),
        .req0_use_carry(req_uc[0]), .req0_set_cc(req_sc[0]),
        .req1_valid(req_valid[1]), .req1_ready(req1_ready),
        .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_opcode(req_op[1]),
        .req1_use_carry(req_uc[1]), .req1_set_cc(req_sc[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .icc(icc), .busy(busy)
    );

    // Returns {N,Z,V,C, y}. 0 ADD(+cin), 1 SUB, 2 AND, 3 OR, 4 XOR, else pass a.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic cin);
        logic [32:0] s;
        logic        c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                c = s[32];
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                c = s[32];
                v = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'd2:    s = {1'b0, a & b};
            4'd3:    s = {1'b0, a | b};
            4'd4:    s = {1'b0, a ^ b};
            default: s = {1'b0, a};
        endcase
        return {s[31], (s[31:0] == 32'd0), v, c, s[31:0]};
    endfunction

    always_comb {alu_flags, alu_y} = alu_ref(alu_a, alu_b, alu_opcode, alu_cin);

    typedef struct {
        logic          id;
        logic [DW-1:0] y;
        logic [3:0]    fl;
        logic [3:0]    icc;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         errors  = 0;
    bit         m_last  = 1'b1;
    logic [3:0] m_icc   = 4'd0;
    bit         m_busy  = 1'b0;
    int         m_age   = 0;
    bit         acc [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Predict the grant from the valids, check ready, and log the transaction.
    task automatic hs_eval();
        int         g;
        logic [35:0] r;
        exp_t       e;
        #1;
        g = -1;
        if (!m_busy) begin
            if (req_valid[0] && req_valid[1]) g = m_last ? 0 : 1;
            else if (req_valid[0])            g = 0;
            else if (req_valid[1])            g = 1;
        end
        chk("req0_ready", 64'(req0_ready), 64'(g == 0));
        chk("req1_ready", 64'(req1_ready), 64'(g == 1));
        if (g >= 0) begin
            r = alu_ref(req_a[g], req_b[g], req_op[g], req_uc[g] & m_icc[0]);
            if (req_sc[g]) m_icc = r[35:32];
            e.id = g[0]; e.y = r[31:0]; e.fl = r[35:32]; e.icc = m_icc;
            q.push_back(e);
            m_last = g[0];
            m_busy = 1'b1;
            m_age  = 0;
            acc[g] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        for (int n = 0; n < 2; n++) if (acc[n]) begin
            req_valid[n] = 1'b0;
            acc[n]       = 1'b0;
        end
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic uc, input logic sc);
        req_a[n] = a; req_b[n] = b; req_op[n] = op;
        req_uc[n] = uc; req_sc[n] = sc; req_valid[n] = 1'b1;
    endtask

    task automatic load_rand(input int n);
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
        set_req(n, a, b, 4'($urandom_range(0, 5)), 1'($urandom), 1'($urandom));
    endtask

    task automatic run_until_idle();
        int c;
        c = 0;
        while ((m_busy || req_valid[0] || req_valid[1]) && c < 100) begin
            tick();
            hs_eval();
            c++;
        end
        if (c >= 100) chk("drain_timeout", 64'(c), 64'd0);
    endtask

    // Monitor: checks latency and each presented response against the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_busy) m_age++;
            if (m_busy && m_age == 2) begin
                chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("exec_busy", 64'(busy), 64'd1);
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                    chk("rsp_y", 64'(rsp_y), 64'(q[0].y));
                    chk("rsp_flags", 64'(rsp_flags), 64'(q[0].fl));
                    chk("icc", 64'(icc), 64'(q[0].icc));
                    chk("rsp_busy", 64'(busy), 64'd1);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        m_busy = 1'b0;
                    end
                end
            end else if (m_busy && m_age >= 3) begin
                chk("rsp_valid_late", 64'(rsp_valid), 64'd1);
            end
        end
    end

    initial begin
        int loads;
        for (int n = 0; n < 2; n++) begin
            req_valid[n] = 1'b0; req_a[n] = '0; req_b[n] = '0;
            req_op[n] = '0; req_uc[n] = 1'b0; req_sc[n] = 1'b0; acc[n] = 1'b0;
        end
        rsp_ready = 1'b1;
        reset     = 1'b1;
        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_icc", 64'(icc), 64'd0);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_op", 64'(alu_opcode), 64'd0);
        chk("rst_alu_cin", 64'(alu_cin), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single add on req0.
        tick();
        set_req(0, 32'h3, 32'h5, 4'd0, 1'b0, 1'b1);
        hs_eval();
        run_until_idle();
        chk("add_icc", 64'(icc), 64'h0);

        // Carry chain on req1: produce C, then consume it.
        tick();
        set_req(1, 32'hFFFF_FFFF, 32'h1, 4'd0, 1'b0, 1'b1);
        hs_eval();
        run_until_idle();
        chk("chain1_icc", 64'(icc), 64'h5);
        tick();
        set_req(1, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0);
        hs_eval();
        tick();
        hs_eval();
        chk("chain2_cin_exec", 64'(alu_cin), 64'd1);
        run_until_idle();
        chk("chain2_icc", 64'(icc), 64'h5);

        // Contention: both valid, four operations.
        tick();
        load_rand(0);
        load_rand(1);
        loads = 2;
        hs_eval();
        for (int c = 0; c < 40 && (m_busy || req_valid[0] || req_valid[1]); c++) begin
            tick();
            for (int n = 0; n < 2; n++) if (!req_valid[n] && loads < 4) begin
                load_rand(n);
                loads++;
            end
            hs_eval();
        end

        // Backpressure: hold the response for several cycles.
        rsp_ready = 1'b0;
        tick();
        load_rand(0);
        hs_eval();
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 3) load_rand(1);
            hs_eval();
        end
        rsp_ready = 1'b1;
        run_until_idle();

        // No-cc op yielding Z: icc must not move.
        tick();
        set_req(1, 32'h5, 32'h5, 4'd1, 1'b0, 1'b0);
        hs_eval();
        run_until_idle();
        chk("nocc_icc", 64'(icc), 64'(m_icc));

        // Reset during EXEC: op is dropped.
        tick();
        set_req(0, 32'h7, 32'h9, 4'd0, 1'b0, 1'b1);
        hs_eval();
        tick();
        hs_eval();
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_icc", 64'(icc), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        q.delete();
        m_busy = 1'b0; m_icc = 4'd0; m_last = 1'b1;
        for (int n = 0; n < 2; n++) begin req_valid[n] = 1'b0; acc[n] = 1'b0; end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin tick(); hs_eval(); end

        // Randomized traffic with random backpressure and occasional valid drops.
        for (int c = 0; c < 400; c++) begin
            tick();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 2; n++) begin
                if (!req_valid[n]) begin
                    if ($urandom_range(0, 2) == 0) load_rand(n);
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[n] = 1'b0;
                end
            end
            hs_eval();
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) if (!m_busy && !acc[n]) req_valid[n] = 1'b0;
        run_until_idle();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and arbiter that shares one combinational `mini_alu` between two requesters, such as the integer-unit issue path and the address/branch helper. It accepts one operation at a time through a valid/ready handshake and drives the ALU operand, opcode and carry inputs from registers. It captures the result and flags, optionally updates the integer condition-code register (icc), and returns a tagged response under backpressure.

## Interface
- `DATA_W`, 32, operand/result width (matches `mini_alu`)
- `OP_W`, 4, opcode width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `reqN_valid`  in  1  (N=0,1) requester N has an operation
- `reqN_ready`  out  1  arbiter accepts requester N this cycle
- `reqN_a`, `reqN_b`  in  DATA_W  operands
- `reqN_opcode`  in  OP_W  ALU opcode, passed through unmodified
- `reqN_use_carry`  in  1  1: alu_cin = icc.C; 0: alu_cin = 0
- `reqN_set_cc`  in  1  1: load icc from ALU flags on completion
- `alu_a`, `alu_b`  out  DATA_W  to `mini_alu`
- `alu_opcode`  out  OP_W  to `mini_alu`
- `alu_cin`  out  1  to `mini_alu`
- `alu_y`  in  DATA_W  from `mini_alu`
- `alu_flags`  in  4  from `mini_alu`; bit order {N,Z,V,C} = [3:0]
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the operation
- `rsp_y`  out  DATA_W  captured result
- `rsp_flags`  out  4  captured flags
- `icc`  out  4  condition-code register {N,Z,V,C}
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among valid requests.
  - If exactly one is valid, grant it.
  - If both are valid, grant the requester that was not granted last, using the `last_grant` register.
  - `reqN_ready` is 1 only for the granted N, and is combinational from the valids and `last_grant`.
  - On handshake, latch a, b, opcode, use_carry, set_cc and id into operand registers, update `last_grant`, and go to EXEC.
- **EXEC**
  - `alu_a`, `alu_b` and `alu_opcode` are driven from the operand registers.
  - `alu_cin` = use_carry ? icc[0] : 0, using the icc value held before this operation.
  - At the clock edge: capture `alu_y` and `alu_flags` into `rsp_y` and `rsp_flags`; if set_cc, load `icc` with `alu_flags`; go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_ready` = 1, go to IDLE.
  - No request is accepted in this state: `reqN_ready` = 0.
- In IDLE and RESP, the ALU inputs hold the last operand register values. The register contents stay stable and are ignored.
- `rsp_y`, `rsp_flags` and `rsp_id` hold their values until the next EXEC capture.
- Reset mid-operation: the in-flight operation is dropped, no response is produced, and icc is cleared.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1 (requester 0 wins the first contention).
  - All operand registers = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_y` = 0, `rsp_flags` = 0, `icc` = 0, `busy` = 0.
  - `alu_a`, `alu_b`, `alu_opcode` and `alu_cin` = 0.
- Handshake at edge E0 → EXEC during cycle E0..E1 → `rsp_valid` = 1 from E1.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP) with `rsp_ready` held high. The next accept can occur at the edge after the response handshake.
- `rsp_ready` low stalls in RESP indefinitely, with outputs stable.
- `icc` changes only at the end of EXEC of a set_cc operation. A use_carry operation immediately following sees the updated C.
- A requester must hold valid and payload stable until it sees ready. Dropping valid before grant is legal; the request is simply not taken.

## Test plan
- **Single add:** req0 a=32'h3, b=32'h5, opcode=4'b0000 (mini_alu ADD), set_cc=1 → req0_ready high in the same cycle; rsp_valid 2 edges later with rsp_id=0, rsp_y=32'h8, rsp_flags=4'b0000; icc=4'b0000.
- **Carry chain:**
  - Step 1: req1 ADD, a=32'hFFFFFFFF, b=32'h1, set_cc=1 → rsp_y=0, rsp_flags=4'b0101, icc=4'b0101.
  - Step 2: req1 ADD, a=0, b=0, use_carry=1, set_cc=0 → alu_cin=1 during EXEC; icc remains 4'b0101.
- **Contention:** both valid continuously for 4 operations → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
- **Backpressure:** rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_y and rsp_flags held; reqN_ready stays 0; the single response completes when rsp_ready rises.
- **Reset mid-operation:** assert reset during EXEC → outputs return to reset values asynchronously (rsp_valid=0, icc=0, busy=0); no response is issued after release.
- **No-cc operation:** set_cc=0 with an ALU result that sets Z → rsp_flags shows Z=1; icc unchanged from its prior value.
